regfile_mp: RTL and testbench

Parametrised multi-port integer register file, the successor to the core's single-write-port register file. It provides N_RD combinational read ports and N_WR write ports with byte strobes, per-lane write-port priority, optional same-cycle write-to-read bypass, and a sequential bulk-clear engine driven by a request/busy/done handshake. It sits in the decode/writeback boundary of the core, shared by all pipeline variants under `rtl/core/common`.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clr_seq.sv | 69 ++++++
 rtl/regfile_mp.sv | 87 ++++++++
 tb/tb_regfile_mp.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file.
// Clear-FSM state encoding and byte-lane helper.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_clr_state_e;

  function automatic int rf_lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks x1..x(N-1) one per cycle.
// Emits a one-hot clear vector plus busy/done.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int N_REGS = 32,
  parameter int ADDR_W = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              idle_o,
  output logic [N_REGS-1:0] clr_vec_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_REGS - 1);

  rf_clr_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req_i) begin
          state_d = RF_CLEAR;
          cnt_d   = ADDR_W'(1);
        end
      end
      RF_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_comb begin
    clr_vec_o = '0;
    if (state_q == RF_CLEAR)
      clr_vec_o[cnt_q] = 1'b1;
  end

  assign clr_busy_o = (state_q == RF_CLEAR);
  assign idle_o     = (state_q == RF_IDLE);
  assign clr_done_o = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte strobes, port priority,
// optional write-to-read bypass and a sequential bulk clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_REGS     = 32,
  parameter int N_RD       = 2,
  parameter int N_WR       = 2,
  parameter int BYPASS     = 1,
  localparam int ADDR_W    = $clog2(N_REGS),
  localparam int NL        = rf_lanes(DATA_WIDTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_RD-1:0][ADDR_W-1:0]         rs_i,
  output logic [N_RD-1:0][DATA_WIDTH-1:0]     rs_data_o,
  input  logic [N_WR-1:0][ADDR_W-1:0]         rd_i,
  input  logic [N_WR-1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [N_WR-1:0]                     wen_i,
  input  logic [N_WR-1:0][NL-1:0]             wstrb_i,
  input  logic                                clr_req_i,
  output logic                                clr_busy_o,
  output logic                                clr_done_o
);

  logic                               idle;
  logic [N_REGS-1:0]                  clr_vec;
  logic [N_REGS-1:0][DATA_WIDTH-1:0]  regs_q;
  logic [N_REGS-1:0][DATA_WIDTH-1:0]  wr_val;

  regfile_clr_seq #(
    .N_REGS (N_REGS),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req_i  (clr_req_i),
    .clr_busy_o (clr_busy_o),
    .clr_done_o (clr_done_o),
    .idle_o     (idle),
    .clr_vec_o  (clr_vec)
  );

  assign regs_q[0] = '0;
  assign wr_val[0] = '0;

  for (genvar r = 1; r < N_REGS; r++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;

    // Later ports overwrite earlier ones, so the highest index wins.
    for (genvar b = 0; b < NL; b++) begin : g_lane
      logic [7:0] v;
      always_comb begin
        v = q[b*8 +: 8];
        for (int p = 0; p < N_WR; p++) begin
          if (idle && wen_i[p] && wstrb_i[p][b] &&
              rd_i[p] == ADDR_W'(r))
            v = wdata_i[p][b*8 +: 8];
        end
      end
      assign wr_val[r][b*8 +: 8] = v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        q <= '0;
      else if (clr_vec[r])
        q <= '0;
      else
        q <= wr_val[r];
    end

    assign regs_q[r] = q;
  end

  // wr_val equals stored data outside IDLE, so bypass is inert there.
  always_comb begin
    rs_data_o = '0;
    for (int r = 0; r < N_RD; r++) begin
      if (rs_i[r] != '0 && int'(rs_i[r]) < N_REGS)
        rs_data_o[r] = (BYPASS != 0) ? wr_val[rs_i[r]]
                                     : regs_q[rs_i[r]];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and
// non-bypass instances share one stimulus stream.
module tb_regfile_mp;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0][4:0]  rs;
  logic [1:0][31:0] rsd_b, rsd_n;
  logic [1:0][4:0]  rd;
  logic [1:0][31:0] wd;
  logic [1:0]       wen;
  logic [1:0][3:0]  ws;
  logic             clr_req;
  logic             busy_b, done_b, busy_n, done_n;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs_i(rs), .rs_data_o(rsd_b),
    .rd_i(rd), .wdata_i(wd), .wen_i(wen), .wstrb_i(ws),
    .clr_req_i(clr_req), .clr_busy_o(busy_b), .clr_done_o(done_b)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs_i(rs), .rs_data_o(rsd_n),
    .rd_i(rd), .wdata_i(wd), .wen_i(wen), .wstrb_i(ws),
    .clr_req_i(clr_req), .clr_busy_o(busy_n), .clr_done_o(done_n)
  );

  function automatic logic [31:0] fill(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {8'hA5, a, ~a, a + 8'd1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all();
    for (int i = 1; i < 32; i++) begin
      rd[0] = 5'(i); wd[0] = fill(i); ws[0] = 4'hF; wen = 2'b01;
      tick();
    end
    wen = 2'b00;
  endtask

  task automatic test_reset();
    rs = '0; rd = '0; wd = '0; wen = '0; ws = '0; clr_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if (busy_b !== 1'b0 || done_b !== 1'b0 || busy_n !== 1'b0) begin
      err++;
      $display("FAIL reset_async busy=%b done=%b exp 0 0", busy_b, done_b);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      rs[0] = 5'(a); rs[1] = 5'(a);
      #1;
      vec++;
      if (rsd_b[0] !== 32'h0 || rsd_b[1] !== 32'h0 || rsd_n[0] !== 32'h0) begin
        err++;
        $display("FAIL reset_read x%0d got %h/%h/%h exp 0", a, rsd_b[0], rsd_b[1], rsd_n[0]);
      end
    end
    rd[0] = 5'd0; wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wen = 2'b01; rs[0] = 5'd0;
    #1;
    vec++;
    if (rsd_b[0] !== 32'h0) begin
      err++;
      $display("FAIL x0_bypass got %h exp 00000000", rsd_b[0]);
    end
    tick();
    wen = 2'b00;
    #1;
    vec++;
    if (rsd_n[0] !== 32'h0) begin
      err++;
      $display("FAIL x0_write got %h exp 00000000", rsd_n[0]);
    end
  endtask

  task automatic test_strobe();
    rd[0] = 5'd5; wd[0] = 32'h11223344; ws[0] = 4'b0101; wen = 2'b01;
    tick();
    wen = 2'b00; rs[0] = 5'd5;
    #1;
    vec++;
    if (rsd_n[0] !== 32'h00220044) begin
      err++;
      $display("FAIL strobe_0101 got %h exp 00220044", rsd_n[0]);
    end
    rd[1] = 5'd5; wd[1] = 32'hAA000000; ws[1] = 4'b1000; wen = 2'b10;
    tick();
    wen = 2'b00;
    #1;
    vec++;
    if (rsd_n[0] !== 32'hAA220044) begin
      err++;
      $display("FAIL strobe_1000 got %h exp AA220044", rsd_n[0]);
    end
  endtask

  task automatic test_collision();
    rd[0] = 5'd7; wd[0] = 32'h11111111; ws[0] = 4'b1111;
    rd[1] = 5'd7; wd[1] = 32'h22222222; ws[1] = 4'b0011;
    wen = 2'b11; rs[1] = 5'd7;
    #1;
    vec++;
    if (rsd_b[1] !== 32'h11112222) begin
      err++;
      $display("FAIL collide_bypass got %h exp 11112222", rsd_b[1]);
    end
    tick();
    wen = 2'b00;
    #1;
    vec++;
    if (rsd_n[1] !== 32'h11112222) begin
      err++;
      $display("FAIL collide got %h exp 11112222", rsd_n[1]);
    end
  endtask

  task automatic test_bypass();
    rd[0] = 5'd3; wd[0] = 32'h12345678; ws[0] = 4'hF; wen = 2'b01;
    rs[0] = 5'd3;
    #1;
    vec++;
    if (rsd_b[0] !== 32'h12345678 || rsd_n[0] !== 32'h0) begin
      err++;
      $display("FAIL bypass_same got %h/%h exp 12345678/00000000", rsd_b[0], rsd_n[0]);
    end
    tick();
    wen = 2'b00;
    #1;
    vec++;
    if (rsd_n[0] !== 32'h12345678) begin
      err++;
      $display("FAIL bypass_next got %h exp 12345678", rsd_n[0]);
    end
  endtask

  task automatic test_clear();
    int nbusy, ndone, done_at;
    fill_all();
    rs[0] = 5'd31;
    #1;
    vec++;
    if (rsd_n[0] !== fill(31)) begin
      err++;
      $display("FAIL fill_x31 got %h exp %h", rsd_n[0], fill(31));
    end
    clr_req = 1'b1;
    rd[0] = 5'd9; wd[0] = 32'hCAFEF00D; ws[0] = 4'hF; wen = 2'b01;
    tick();
    clr_req = 1'b0; wen = 2'b00; rs[0] = 5'd9;
    #1;
    vec++;
    if (busy_b !== 1'b1 || rsd_n[0] !== 32'hCAFEF00D) begin
      err++;
      $display("FAIL clr_start busy=%b x9=%h exp 1 CAFEF00D", busy_b, rsd_n[0]);
    end
    nbusy = 1; ndone = 0; done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (busy_b) nbusy++;
      if (done_b) begin ndone++; done_at = c; end
      if (c == 5) begin
        rs[0] = 5'd5; rs[1] = 5'd6;
        #1;
        vec++;
        if (rsd_n[0] !== 32'h0 || rsd_n[1] !== fill(6)) begin
          err++;
          $display("FAIL clr_partial x5=%h x6=%h exp 0 %h", rsd_n[0], rsd_n[1], fill(6));
        end
        rd[0] = 5'd1; wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF; wen = 2'b01;
        rs[0] = 5'd1;
        #1;
        vec++;
        if (rsd_b[0] !== 32'h0) begin
          err++;
          $display("FAIL clr_nobypass got %h exp 00000000", rsd_b[0]);
        end
      end
      if (c == 6) wen = 2'b00;
    end
    vec++;
    if (nbusy !== 31 || ndone !== 1 || done_at !== 31) begin
      err++;
      $display("FAIL clr_timing busy=%0d done=%0d at=%0d exp 31 1 31", nbusy, ndone, done_at);
    end
    for (int a = 0; a < 32; a++) begin
      rs[0] = 5'(a);
      #1;
      vec++;
      if (rsd_n[0] !== 32'h0 || rsd_b[0] !== 32'h0) begin
        err++;
        $display("FAIL clr_after x%0d got %h exp 00000000", a, rsd_n[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    c = 1;
    while (!done_b && c < 40) begin tick(); c++; end
    vec++;
    if (!done_b) begin
      err++;
      $display("FAIL b2b_first_done got 0 exp 1 within 40");
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    vec++;
    if (busy_b !== 1'b1 || done_b !== 1'b0) begin
      err++;
      $display("FAIL b2b_accept busy=%b done=%b exp 1 0", busy_b, done_b);
    end
    c = 0;
    while (!done_b && c < 40) begin tick(); c++; end
    vec++;
    if (c !== 31) begin
      err++;
      $display("FAIL b2b_len got %0d exp 31", c);
    end
  endtask

  task automatic test_abort();
    int bad, c;
    fill_all();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (busy_b !== 1'b0 || done_b !== 1'b0) begin
      err++;
      $display("FAIL abort_state busy=%b done=%b exp 0 0", busy_b, done_b);
    end
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rs[0] = 5'(a);
      #1;
      if (rsd_n[0] !== 32'h0) bad++;
    end
    vec++;
    if (bad != 0) begin
      err++;
      $display("FAIL abort_regs got %0d nonzero exp 0", bad);
    end
    tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done_b || busy_b) bad++;
    end
    vec++;
    if (bad != 0) begin
      err++;
      $display("FAIL abort_quiet got %0d busy/done cycles exp 0", bad);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    vec++;
    if (busy_b !== 1'b1) begin
      err++;
      $display("FAIL abort_reaccept busy=%b exp 1", busy_b);
    end
    c = 0;
    while (!done_b && c < 40) begin tick(); c++; end
    vec++;
    if (c !== 31) begin
      err++;
      $display("FAIL abort_len got %0d exp 31", c);
    end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_collision();
    test_bypass();
    test_clear();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
